demux1to4_stream: RTL and testbench

//  Registered 1-to-4 demultiplexer with valid/ready handshake. It is the distribution-side

---
 rtl/demux_stream_pkg.sv | 26 ++
 rtl/demux_chan_slot.sv | 45 ++++
 rtl/demux1to4_stream.sv | 52 +++++
 tb/tb_demux1to4_stream.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_stream_pkg.sv
// Shared constants for the 1-to-4 stream demultiplexer.
package demux_stream_pkg;

    localparam int NCH = 4;

    localparam logic [1:0] CH0 = 2'd0;
    localparam logic [1:0] CH1 = 2'd1;
    localparam logic [1:0] CH2 = 2'd2;
    localparam logic [1:0] CH3 = 2'd3;

    typedef logic [1:0] sel_t;

    // One-hot channel mask for a select code.
    function automatic logic [NCH-1:0] sel_onehot(input sel_t s);
        logic [NCH-1:0] m;
        m = '0;
        case (s)
            CH0:     m[0] = 1'b1;
            CH1:     m[1] = 1'b1;
            CH2:     m[2] = 1'b1;
            default: m[3] = 1'b1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/demux_chan_slot.sv
// Single-entry holding slot for one output channel, with its delivered-word counter.
module demux_chan_slot #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CNT_W-1:0]  cnt
);

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drain;

    always_comb begin
        drain   = valid_q & ready;
        // A load wins over a drain so the slot stays full on drain+refill.
        valid_d = load | (valid_q & ~ready);
        data_d  = load ? ld_data : data_q;
        cnt_d   = drain ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign cnt   = cnt_q;

endmodule

// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 stream demultiplexer: steers each accepted word to the slot chosen
// by sel, or to all four slots at once when bcast is set.
module demux1to4_stream
    import demux_stream_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [1:0]            sel,
    input  logic                  bcast,
    output logic [NCH-1:0]        out_valid,
    input  logic [NCH-1:0]        out_ready,
    output logic [NCH*DATA_W-1:0] out_data,
    output logic [NCH*CNT_W-1:0]  xfer_cnt
);

    logic [NCH-1:0] free;
    logic [NCH-1:0] target;
    logic [NCH-1:0] load;
    logic           accept;

    // A full slot whose consumer is taking its word this cycle can be refilled now.
    always_comb begin
        free     = ~out_valid | out_ready;
        target   = bcast ? {NCH{1'b1}} : sel_onehot(sel);
        in_ready = bcast ? &free : |(free & target);
        accept   = in_valid & in_ready;
        load     = accept ? target : '0;
    end

    for (genvar k = 0; k < NCH; k++) begin : g_slot
        demux_chan_slot #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (load[k]),
            .ld_data (in_data),
            .ready   (out_ready[k]),
            .valid   (out_valid[k]),
            .data    (out_data[k*DATA_W +: DATA_W]),
            .cnt     (xfer_cnt[k*CNT_W +: CNT_W])
        );
    end

endmodule

// File: tb/tb_demux1to4_stream.sv
// Self-checking bench for demux1to4_stream against a per-channel slot/count model.
module tb_demux1to4_stream;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [1:0]    sel = '0;
    logic          bcast = 1'b0;
    logic [3:0]    out_valid;
    logic [3:0]    out_ready = '0;
    logic [4*DW-1:0] out_data;
    logic [4*CW-1:0] xfer_cnt;

    int pass_n = 0;
    int total_n = 0;

    // Reference model: which channels hold a word, the last word loaded, delivered counts.
    logic [3:0] mv;
    logic [7:0] md [4];
    int         mc [4];
    int         acc_n [4];
    int         drn_obs [4];

    demux1to4_stream #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .sel(sel), .bcast(bcast), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ch_data(input int k);
        return out_data[k*DW +: DW];
    endfunction

    function automatic int ch_cnt(input int k);
        return int'(xfer_cnt[k*CW +: CW]);
    endfunction

    task automatic model_clear();
        mv = '0;
        for (int k = 0; k < 4; k++) begin
            md[k] = '0; mc[k] = 0; acc_n[k] = 0; drn_obs[k] = 0;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; in_valid = 1'b0; bcast = 1'b0; sel = '0; out_ready = '0; in_data = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    // Drive one cycle; called #1 after a rising edge, returns #1 after the next one.
    task automatic step(input logic iv, input logic [7:0] d, input logic [1:0] s,
                        input logic bc, input logic [3:0] ordy,
                        output logic ir_dut, output logic ir_exp);
        logic all_free, acc;
        in_valid = iv; in_data = d; sel = s; bcast = bc; out_ready = ordy;
        all_free = 1'b1;
        for (int k = 0; k < 4; k++) if (mv[k] && !ordy[k]) all_free = 1'b0;
        ir_exp = bc ? all_free : (!mv[s] || ordy[s]);
        acc = iv && ir_exp;
        @(negedge clk);
        ir_dut = in_ready;
        for (int k = 0; k < 4; k++) if (out_valid[k] && out_ready[k]) drn_obs[k]++;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (mv[k] && ordy[k]) begin
                mc[k] = (mc[k] + 1) % (1 << CW);
                mv[k] = 1'b0;
            end
            if (acc && (bc || int'(s) == k)) begin
                mv[k] = 1'b1; md[k] = d; acc_n[k]++;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        total_n++;
        if (out_valid !== 4'b0000 || xfer_cnt !== '0 || out_data !== '0)
            $display("FAIL reset_state: valid=%b cnt=%h data=%h want 0/0/0", out_valid, xfer_cnt, out_data);
        else pass_n++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        sel = 2'd0; bcast = 1'b0; #1;
        total_n++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else pass_n++;
        bcast = 1'b1; #1;
        total_n++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready_bcast: got %b want 1", in_ready);
        else pass_n++;
        bcast = 1'b0;
    endtask

    task automatic test_route();
        logic ird, ire;
        apply_reset();
        step(1'b1, 8'hA5, 2'd2, 1'b0, 4'b0000, ird, ire);
        total_n++;
        if (ird !== 1'b1) $display("FAIL route_ready: got %b want 1", ird);
        else pass_n++;
        total_n++;
        if (out_valid !== 4'b0100) $display("FAIL route_valid: got %b want 0100", out_valid);
        else pass_n++;
        total_n++;
        if (ch_data(2) !== 8'hA5 || ch_data(0) !== 8'h00 || ch_data(1) !== 8'h00 || ch_data(3) !== 8'h00)
            $display("FAIL route_data: got %h want 00a50000", out_data);
        else pass_n++;
    endtask

    task automatic test_backpressure();
        logic ird, ire;
        apply_reset();
        step(1'b1, 8'h11, 2'd1, 1'b0, 4'b0000, ird, ire);
        step(1'b1, 8'h22, 2'd1, 1'b0, 4'b0000, ird, ire);
        total_n++;
        if (ird !== 1'b0 || ch_data(1) !== 8'h11 || out_valid !== 4'b0010)
            $display("FAIL bp_stall: ready=%b data=%h valid=%b want 0/11/0010", ird, ch_data(1), out_valid);
        else pass_n++;
        step(1'b1, 8'h22, 2'd1, 1'b0, 4'b0010, ird, ire);
        total_n++;
        if (ird !== 1'b1) $display("FAIL bp_refill_ready: got %b want 1", ird);
        else pass_n++;
        total_n++;
        if (out_valid !== 4'b0010 || ch_data(1) !== 8'h22 || ch_cnt(1) !== 1)
            $display("FAIL bp_refill: valid=%b data=%h cnt=%0d want 0010/22/1", out_valid, ch_data(1), ch_cnt(1));
        else pass_n++;
    endtask

    task automatic test_broadcast();
        logic ird, ire;
        apply_reset();
        step(1'b1, 8'h3C, 2'd3, 1'b0, 4'b0000, ird, ire);
        step(1'b1, 8'h5A, 2'd0, 1'b1, 4'b0000, ird, ire);
        total_n++;
        if (ird !== 1'b0 || out_valid !== 4'b1000 || ch_data(3) !== 8'h3C || ch_data(0) !== 8'h00)
            $display("FAIL bcast_blocked: ready=%b valid=%b data=%h", ird, out_valid, out_data);
        else pass_n++;
        step(1'b1, 8'h5A, 2'd0, 1'b1, 4'b1000, ird, ire);
        total_n++;
        if (ird !== 1'b1 || out_valid !== 4'b1111 || out_data !== 32'h5A5A5A5A || ch_cnt(3) !== 1)
            $display("FAIL bcast_all: ready=%b valid=%b data=%h cnt3=%0d want 1/1111/5a5a5a5a/1",
                     ird, out_valid, out_data, ch_cnt(3));
        else pass_n++;
    endtask

    task automatic test_wrap();
        logic ird, ire;
        apply_reset();
        // First step only fills ch0; each of the next 16 drains one word while refilling.
        for (int i = 0; i < 17; i++) step(1'b1, 8'(i), 2'd0, 1'b0, 4'b0001, ird, ire);
        total_n++;
        if (ch_cnt(0) !== 0 || out_valid[0] !== 1'b1)
            $display("FAIL wrap_16: cnt=%0d valid0=%b want 0/1", ch_cnt(0), out_valid[0]);
        else pass_n++;
        step(1'b0, 8'h00, 2'd0, 1'b0, 4'b0001, ird, ire);
        total_n++;
        if (ch_cnt(0) !== 1 || out_valid[0] !== 1'b0)
            $display("FAIL wrap_17: cnt=%0d valid0=%b want 1/0", ch_cnt(0), out_valid[0]);
        else pass_n++;
    endtask

    task automatic test_reset_midop();
        logic ird, ire;
        apply_reset();
        step(1'b1, 8'h77, 2'd0, 1'b0, 4'b0001, ird, ire);
        step(1'b1, 8'h99, 2'd0, 1'b1, 4'b0001, ird, ire);
        total_n++;
        if (out_valid !== 4'b1111 || ch_cnt(0) !== 1)
            $display("FAIL midop_fill: valid=%b cnt0=%0d want 1111/1", out_valid, ch_cnt(0));
        else pass_n++;
        #1 rst_n = 1'b0;
        #1;
        total_n++;
        if (out_valid !== 4'b0000 || xfer_cnt !== '0)
            $display("FAIL midop_async: valid=%b cnt=%h want 0000/0", out_valid, xfer_cnt);
        else pass_n++;
        #1 rst_n = 1'b1;
        in_valid = 1'b0;
        model_clear();
        @(posedge clk); #1;
        step(1'b1, 8'hC3, 2'd1, 1'b0, 4'b0000, ird, ire);
        total_n++;
        if (out_valid !== 4'b0010 || ch_data(1) !== 8'hC3)
            $display("FAIL midop_after: valid=%b data1=%h want 0010/c3", out_valid, ch_data(1));
        else pass_n++;
    endtask

    task automatic test_random();
        logic ird, ire;
        logic iv, bc;
        logic [7:0] d;
        logic [1:0] s;
        logic held;
        int bad;
        apply_reset();
        held = 1'b0; iv = 1'b0; bc = 1'b0; d = '0; s = '0;
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            // A stalled word must stay put until accepted.
            if (!held) begin
                iv = ($urandom_range(0, 3) != 0);
                d  = 8'($urandom);
                s  = 2'($urandom_range(0, 3));
                bc = ($urandom_range(0, 7) == 0);
            end
            step(iv, d, s, bc, 4'($urandom), ird, ire);
            held = iv && !ire;
            total_n++;
            if (ird !== ire) begin
                $display("FAIL rand_in_ready c=%0d: got %b want %b", c, ird, ire);
                continue;
            end
            if (out_valid !== mv) begin
                $display("FAIL rand_valid c=%0d: got %b want %b", c, out_valid, mv);
                continue;
            end
            bad = 0;
            for (int k = 0; k < 4; k++)
                if (ch_data(k) !== md[k] || ch_cnt(k) !== mc[k]) bad = k + 1;
            if (bad != 0)
                $display("FAIL rand_chan c=%0d ch%0d: data=%h cnt=%0d want %h/%0d",
                         c, bad - 1, ch_data(bad - 1), ch_cnt(bad - 1), md[bad - 1], mc[bad - 1]);
            else pass_n++;
        end
        for (int k = 0; k < 4; k++) begin
            total_n++;
            if (acc_n[k] != drn_obs[k] + int'(out_valid[k]))
                $display("FAIL rand_conserve ch%0d: accepted=%0d drained=%0d held=%b",
                         k, acc_n[k], drn_obs[k], out_valid[k]);
            else pass_n++;
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_route();
        test_backpressure();
        test_broadcast();
        test_wrap();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
